// File: rtl/ecc_pkg.sv
// Shared SEC-DED definitions: check-width sizing, codeword position mapping
// and the error classification used by the decoder pipeline.
package ecc_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CE,
    ERR_UE
  } err_kind_e;

  // Smallest r such that 2^r >= data_w + r + 1 (number of Hamming check bits).
  function automatic int calc_r(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  // Total check width: Hamming bits plus the overall parity bit.
  function automatic int calc_chk_w(input int data_w);
    return calc_r(data_w) + 1;
  endfunction

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_CHK_W  = calc_chk_w(DEFAULT_DATA_W);

  // Codeword position (1-based) of data bit idx. Data bits fill the
  // non-power-of-2 positions in ascending order; each power of two at or
  // below the running position pushes the data bit one slot further up.
  function automatic int data_pos(input int idx);
    int pos;
    pos = idx + 1;
    for (int i = 0; i < 9; i++) begin
      if ((1 << i) <= pos) pos = pos + 1;
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome / overall-parity generator for an extended Hamming
// codeword. syn is the XOR of the positions of all set codeword bits.
module secded_syndrome
  import ecc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int R      = calc_r(DATA_W)
) (
  input  logic [DATA_W-1:0] in_data,
  input  logic [R:0]        in_chk,
  output logic [R-1:0]      syn,
  output logic              pm
);

  // Fold every set data bit's position into the received Hamming bits.
  always_comb begin
    // NOTE: every variable written here gets a value before any condition, so no latch is inferred.
    syn = in_chk[R-1:0];
    for (int j = 0; j < DATA_W; j++) begin
      if (in_data[j]) syn = syn ^ R'(data_pos(j));
    end
    pm = ^{in_data, in_chk};
  end

endmodule

// File: rtl/secded_decoder_pipe.sv
// Two-stage pipelined SEC-DED decoder with valid/ready handshaking and
// saturating correctable/uncorrectable error counters.
// Optional build macro ECC_ERR_INJECT_EN adds inj_mask/inj_en ports that XOR
// an error pattern into the accepted codeword before decode.
module secded_decoder_pipe
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int R      = calc_r(DATA_W),
  localparam int CHK_W  = R + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              corr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ce,
  output logic              out_ue,
  output logic [R-1:0]      out_syn,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt
`ifdef ECC_ERR_INJECT_EN
  ,
  input  logic [DATA_W+CHK_W-1:0] inj_mask,
  input  logic                    inj_en
`endif
);

  localparam int LAST_POS = DATA_W + R;

  logic              v1, v2;
  logic              e1, e2;
  logic [DATA_W-1:0] dec_data;
  logic [CHK_W-1:0]  dec_chk;
  logic [R-1:0]      syn_d;
  logic              pm_d;

  logic [DATA_W-1:0] d1;
  logic [R-1:0]      syn1;
  logic              pm1;
  logic              corr1;

  err_kind_e         kind;
  logic [DATA_W-1:0] fixed_data;
  logic              hs_out;

  // Ready chain: a stage can load when it is empty or its successor drains.
  assign e2       = !v2 || out_ready;
  assign e1       = !v1 || e2;
  assign in_ready = e1;
  assign out_valid = v2;
  assign hs_out   = v2 && out_ready;

`ifdef ECC_ERR_INJECT_EN
  assign {dec_chk, dec_data} = {in_chk, in_data} ^ (inj_en ? inj_mask : '0);
`else
  assign dec_data = in_data;
  assign dec_chk  = in_chk;
`endif

  secded_syndrome #(
    .DATA_W (DATA_W),
    .R      (R)
  ) u_syndrome (
    .in_data (dec_data),
    .in_chk  (dec_chk),
    .syn     (syn_d),
    .pm      (pm_d)
  );

  // Stage 1 occupancy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      v1 <= 1'b0;
    end else if (e1) begin
      v1 <= in_valid;
    end
  end

  // Stage 1 payload: raw data, syndrome, parity mismatch and correction enable.
  always_ff @(posedge clk) begin
    // NOTE: payload flops are left unreset; v1 qualifies them, so no reset fan-out is spent here.
    if (e1 && in_valid) begin
      d1    <= dec_data;
      syn1  <= syn_d;
      pm1   <= pm_d;
      corr1 <= corr_en;
    end
  end

  // Classify the stage-1 word and build the (optionally) corrected data.
  always_comb begin
    kind       = ERR_NONE;
    fixed_data = d1;
    if (syn1 == '0) begin
      kind = pm1 ? ERR_CE : ERR_NONE;
    end else if (!pm1) begin
      kind = ERR_UE;
    end else if (int'(syn1) > LAST_POS) begin
      kind = ERR_UE;
    end else begin
      kind = ERR_CE;
      if (corr1) begin
        for (int j = 0; j < DATA_W; j++) begin
          if (int'(syn1) == data_pos(j)) fixed_data[j] = ~d1[j];
        end
      end
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2       <= 1'b0;
      out_data <= '0;
      out_ce   <= 1'b0;
      out_ue   <= 1'b0;
      out_syn  <= '0;
    end else if (e2) begin
      v2 <= v1;
      if (v1) begin
        out_data <= fixed_data;
        out_ce   <= (kind == ERR_CE);
        out_ue   <= (kind == ERR_UE);
        out_syn  <= syn1;
      end
    end
  end

  // Saturating error counters advanced on delivered words; clear wins.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ce_cnt <= '0;
      ue_cnt <= '0;
    end else if (hs_out) begin
      if (out_ce && ce_cnt != '1) ce_cnt <= ce_cnt + CNT_W'(1);
      if (out_ue && ue_cnt != '1) ue_cnt <= ue_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Self-checking bench for secded_decoder_pipe (DATA_W=32, CNT_W=4):
// directed vector table, backpressure, counter saturation/clear, randomized
// traffic against a position-level codeword model, and mid-stream reset.
module tb_secded_decoder_pipe;

  localparam int DW   = 32;
  localparam int RR   = 6;
  localparam int CW   = RR + 1;
  localparam int NPOS = DW + RR;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [CW-1:0]   in_chk;
  logic            corr_en;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_ce;
  logic            out_ue;
  logic [RR-1:0]   out_syn;
  logic            cnt_clr;
  logic [CNTW-1:0] ce_cnt;
  logic [CNTW-1:0] ue_cnt;

  secded_decoder_pipe #(
    .DATA_W (DW),
    .CNT_W  (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_chk    (in_chk),
    .corr_en   (corr_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ce    (out_ce),
    .out_ue    (out_ue),
    .out_syn   (out_syn),
    .cnt_clr   (cnt_clr),
    .ce_cnt    (ce_cnt),
    .ue_cnt    (ue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          ce;
    logic          ue;
    logic [RR-1:0] syn;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] chk;
    logic          corr;
    logic [DW-1:0] e_data;
    logic          e_ce;
    logic          e_ue;
    logic [RR-1:0] e_syn;
    string         name;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t          exp_q[$];
  int            exp_ce_cnt;
  int            exp_ue_cnt;
  bit            use_tab;
  exp_t          tab_exp;
  bit            last_in_hs;
  bit            last_out_hs;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic [RR+1:0] prev_flags;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference decode: lay the word out bit-by-bit in codeword positions,
  // XOR positions of set bits, and classify by the extended-Hamming rules.
  function automatic exp_t ref_decode(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                      input logic corr);
    exp_t e;
    int   syn;
    bit   par;
    int   k;
    int   idx_of[NPOS+1];
    bit   b;
    k   = 0;
    syn = 0;
    par = c[RR];
    idx_of[0] = -1;
    for (int p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) == 0) begin
        b = c[$clog2(p)];
        idx_of[p] = -1;
      end else begin
        b = d[k];
        idx_of[p] = k;
        k++;
      end
      if (b) syn = syn ^ p;
      par = par ^ b;
    end
    e.data = d;
    e.ce   = 1'b0;
    e.ue   = 1'b0;
    e.syn  = syn[RR-1:0];
    if (syn == 0) begin
      e.ce = par;
    end else if (!par || syn > NPOS) begin
      e.ue = 1'b1;
    end else begin
      e.ce = 1'b1;
      if (corr && idx_of[syn] >= 0) e.data[idx_of[syn]] = ~d[idx_of[syn]];
    end
    return e;
  endfunction

  // Reference encoder producing a clean codeword's check bits.
  function automatic logic [CW-1:0] ref_encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int syn;
    bit par;
    int k;
    syn = 0;
    par = 1'b0;
    k   = 0;
    for (int p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) syn = syn ^ p;
        par = par ^ d[k];
        k++;
      end
    end
    c[RR-1:0] = syn[RR-1:0];
    c[RR]     = par ^ (^syn[RR-1:0]);
    return c;
  endfunction

  // One clock: sample at the falling edge, score, then return at posedge+1.
  task automatic step();
    exp_t e;
    bit   popped;
    @(negedge clk);
    check("ce_cnt", ce_cnt, exp_ce_cnt);
    check("ue_cnt", ue_cnt, exp_ue_cnt);
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
      check("hold_flags", {out_ce, out_ue, out_syn}, prev_flags);
    end
    last_out_hs = out_valid && out_ready;
    last_in_hs  = in_valid && in_ready;
    popped      = 1'b0;
    if (last_out_hs) begin
      if (exp_q.size() == 0) begin
        check("out_without_input", last_out_hs, 0);
      end else begin
        e      = exp_q.pop_front();
        popped = 1'b1;
        check("out_data", out_data, e.data);
        check("out_ce", out_ce, e.ce);
        check("out_ue", out_ue, e.ue);
        check("out_syn", out_syn, e.syn);
      end
    end
    if (cnt_clr) begin
      exp_ce_cnt = 0;
      exp_ue_cnt = 0;
    end else if (popped) begin
      if (e.ce && exp_ce_cnt < CMAX) exp_ce_cnt++;
      if (e.ue && exp_ue_cnt < CMAX) exp_ue_cnt++;
    end
    if (last_in_hs) exp_q.push_back(use_tab ? tab_exp : ref_decode(in_data, in_chk, corr_en));
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_flags = {out_ce, out_ue, out_syn};
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_ce_cnt = 0;
    exp_ue_cnt = 0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  vec_t          tab[11];
  logic [DW-1:0] wd[4];
  logic [CW-1:0] wc[4];
  logic [DW+CW-1:0] cwv;

  initial begin
    int acc;
    int hs;
    int delivered;
    int f1;
    int f2;
    int nflip;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chk    = '0;
    corr_en   = 1'b1;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    use_tab   = 1'b0;
    clear_model();
    do_reset();

    // Reset state.
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_flags_syn", {out_ce, out_ue, out_syn}, 0);
    check("rst_ce_cnt", ce_cnt, 0);
    check("rst_ue_cnt", ue_cnt, 0);

    // Directed vectors with hand-derived expectations.
    tab[0]  = '{32'h0000_0000, 7'h00, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 6'd0,  "clean"};
    tab[1]  = '{32'h0000_0001, 7'h00, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd3,  "sec_d0"};
    tab[2]  = '{32'h0000_0001, 7'h00, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 6'd3,  "sec_d0_raw"};
    tab[3]  = '{32'h0000_0003, 7'h00, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 6'd6,  "ded"};
    tab[4]  = '{32'h0000_0000, 7'h40, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd0,  "parity_only"};
    tab[5]  = '{32'h0000_0000, 7'h01, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd1,  "chk0_err"};
    tab[6]  = '{32'h0000_0000, 7'h20, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd32, "chk5_err"};
    tab[7]  = '{32'h8000_0000, 7'h00, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd38, "sec_d31_lastpos"};
    tab[8]  = '{32'h0000_0000, 7'h67, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 6'd39, "syn_out_of_range"};
    tab[9]  = '{32'hFFFF_FFFF, 7'h18, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'd0,  "clean_ones"};
    tab[10] = '{32'hFFFF_FFFE, 7'h18, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'd3,  "sec_ones"};

    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_data      = tab[i].data;
      in_chk       = tab[i].chk;
      corr_en      = tab[i].corr;
      tab_exp.data = tab[i].e_data;
      tab_exp.ce   = tab[i].e_ce;
      tab_exp.ue   = tab[i].e_ue;
      tab_exp.syn  = tab[i].e_syn;
      use_tab      = 1'b1;
      in_valid     = 1'b1;
      last_in_hs   = 1'b0;
      for (int c = 0; c < 10 && !last_in_hs; c++) step();
      check({"tab_accept_", tab[i].name}, last_in_hs, 1);
      in_valid = 1'b0;
      use_tab  = 1'b0;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) step();
      check({"tab_drain_", tab[i].name}, exp_q.size(), 0);
    end
    check("tab_ue_cnt_total", ue_cnt, 2);
    check("tab_ce_cnt_total", ce_cnt, 7);

    // Backpressure: four back-to-back words against a stalled consumer.
    do_reset();
    corr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      wc[i] = ref_encode(wd[i]);
      if (i < 2) wd[i][i * 7] = ~wd[i][i * 7];
    end
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (acc < 4);
      if (acc < 4) begin
        in_data = wd[acc];
        in_chk  = wc[acc];
      end
      step();
      if (last_in_hs) acc++;
    end
    check("bp_accepted_while_stalled", acc, 2);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    delivered = 0;
    for (int c = 0; c < 30 && !(acc == 4 && exp_q.size() == 0); c++) begin
      in_valid = (acc < 4);
      if (acc < 4) begin
        in_data = wd[acc];
        in_chk  = wc[acc];
      end
      step();
      if (last_in_hs) acc++;
      if (last_out_hs) delivered++;
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("bp_delivered", delivered, 4);

    // Counter saturation and clear-over-increment (CNT_W=4).
    do_reset();
    out_ready = 1'b1;
    corr_en   = 1'b1;
    in_data   = 32'h1;
    in_chk    = 7'h00;
    acc = 0;
    hs  = 0;
    for (int c = 0; c < 80 && hs < 20; c++) begin
      in_valid = (acc < 20);
      cnt_clr  = out_valid && out_ready && (hs == 19);
      step();
      if (last_in_hs) acc++;
      if (last_out_hs) begin
        hs++;
        if (hs == 15) check("cnt_reach_15", ce_cnt, 15);
        if (hs == 17) check("cnt_hold_15_a", ce_cnt, 15);
        if (hs == 19) check("cnt_hold_15_b", ce_cnt, 15);
        if (hs == 20) check("cnt_clr_wins", ce_cnt, 0);
      end
    end
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    check("cnt_handshakes", hs, 20);
    repeat (3) step();

    // Randomized traffic with random stalls, clears and 0/1/2/garbage errors.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      corr_en   = $urandom_range(0, 1);
      in_data   = $urandom;
      in_chk    = ref_encode(in_data);
      nflip     = $urandom_range(0, 3);
      cwv       = {in_chk, in_data};
      f1        = $urandom_range(0, DW + CW - 1);
      f2        = (f1 + $urandom_range(1, DW + CW - 1)) % (DW + CW);
      if (nflip >= 1) cwv[f1] = ~cwv[f1];
      if (nflip == 2) cwv[f2] = ~cwv[f2];
      {in_chk, in_data} = cwv;
      if (nflip == 3) in_chk = CW'($urandom);
      step();
    end
    cnt_clr   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) step();
    check("rand_drain", exp_q.size(), 0);

    // Reset mid-stream drops in-flight words and clears the counters.
    in_data  = 32'h1;
    in_chk   = 7'h00;
    corr_en  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid  = 1'b1;
      out_ready = (c > 1);
      step();
    end
    check("pre_rst_ce_nonzero", (ce_cnt != 0), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ce_cnt", ce_cnt, 0);
    check("midrst_ue_cnt", ue_cnt, 0);
    check("midrst_in_ready", in_ready, 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    clear_model();
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
